// File: rtl/sampler_pkg.sv
// Shared types and constants for the ADC sample sequencer.
package sampler_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  localparam int SAMPLE_W = 12;
  localparam int OVR_W    = 8;
endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO with registered head; head valid the cycle after the first push.
// Push while full is refused unless a pop frees a slot on the same edge.
module sample_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      count;
  logic             do_pop;
  logic             do_push;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      head   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      // The incoming word becomes head when it lands in an empty (or emptying) FIFO.
      if (do_push && (empty || (do_pop && count == (AW+1)'(1))))
        head <= din;
      else if (do_pop && count > (AW+1)'(1))
        head <= mem[rd_ptr[AW-1:0] + AW'(1)];
    end
  end
endmodule

// File: rtl/sample_sequencer.sv
// Programmable sample strobe, ADC capture and buffered valid/ready delivery.
// Burst/continuous modes; samples arriving at a full, non-popping FIFO are dropped and counted.
module sample_sequencer
  import sampler_pkg::*;
#(
  parameter int SAMPLE_W = sampler_pkg::SAMPLE_W,
  parameter int DIV_W    = 16,
  parameter int BURST_W  = 16,
  parameter int DEPTH    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  input  logic [DIV_W-1:0]    divisor,
  input  logic [BURST_W-1:0]  burst_len,
  input  logic [SAMPLE_W-1:0] adc_data,
  output logic                sample_tick,
  output logic [SAMPLE_W-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic                done,
  output logic                overrun,
  output logic [OVR_W-1:0]    overrun_cnt
);
  state_t               state;
  state_t               state_nxt;
  logic [DIV_W-1:0]     div_q;
  logic [DIV_W-1:0]     div_clamp;
  logic [DIV_W-1:0]     cnt;
  logic [BURST_W-1:0]   burst_q;
  logic [BURST_W-1:0]   n_taken;
  logic                 push;
  logic                 pop;
  logic                 last_sample;
  logic                 fifo_full;
  logic                 fifo_empty;

  assign div_clamp   = (divisor < DIV_W'(2)) ? DIV_W'(2) : divisor;
  assign push        = (state == RUN) && (cnt == '0);
  assign pop         = out_valid && out_ready;
  assign out_valid   = !fifo_empty;
  assign busy        = (state != IDLE);
  assign last_sample = (burst_q != '0) && ((n_taken + BURST_W'(1)) == burst_q);

  sample_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (adc_data),
    .pop   (pop),
    .head  (out_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (stop || (push && last_sample)) state_nxt = DRAIN;
      DRAIN:   if (fifo_empty) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      div_q       <= DIV_W'(2);
      cnt         <= '0;
      burst_q     <= '0;
      n_taken     <= '0;
      sample_tick <= 1'b0;
      done        <= 1'b0;
      overrun     <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      state       <= state_nxt;
      sample_tick <= push;
      done        <= (state == DRAIN) && fifo_empty;
      if (state == IDLE && start) begin
        div_q       <= div_clamp;
        cnt         <= div_clamp - DIV_W'(1);
        burst_q     <= burst_len;
        n_taken     <= '0;
        overrun     <= 1'b0;
        overrun_cnt <= '0;
      end else if (state == RUN) begin
        if (cnt != '0) begin
          cnt <= cnt - DIV_W'(1);
        end else begin
          cnt     <= div_q - DIV_W'(1);
          n_taken <= n_taken + BURST_W'(1);
          // Dropped samples still count toward the burst length.
          if (fifo_full && !pop) begin
            overrun <= 1'b1;
            if (overrun_cnt != {OVR_W{1'b1}}) overrun_cnt <= overrun_cnt + OVR_W'(1);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_sample_sequencer.sv
// Scoreboard bench for sample_sequencer: a cycle model predicts pushes, drops and done.
module tb_sample_sequencer;
  localparam int SW    = 12;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          stop;
  logic [15:0]   divisor;
  logic [15:0]   burst_len;
  logic [SW-1:0] adc_data;
  logic          sample_tick;
  logic [SW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;
  logic          overrun;
  logic [7:0]    overrun_cnt;

  always #5 clk = ~clk;

  sample_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .divisor     (divisor),
    .burst_len   (burst_len),
    .adc_data    (adc_data),
    .sample_tick (sample_tick),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun),
    .overrun_cnt (overrun_cnt)
  );

  int n_chk = 0;
  int n_fail = 0;
  int edge_cnt = 0;
  int q[$];
  int phase = 0;
  int m_div, m_burst, m_taken, m_ovr, next_push, e0, done_edge;
  bit exp_done;
  int pops, tick_count, last_tick_edge, tick_gap;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    bit pre_empty, pop_now, push_now, start_now, stop_now;
    int d;
    pre_empty = (q.size() == 0);
    pop_now   = !pre_empty && out_ready;
    if (pop_now) begin
      chk("pop_data", int'(out_data), q.pop_front());
      pops++;
    end
    push_now  = (phase == 1) && (edge_cnt + 1 == next_push);
    start_now = start && (phase == 0);
    stop_now  = stop;
    d = (divisor < 16'd2) ? 2 : int'(divisor);
    @(posedge clk);
    edge_cnt++;
    exp_done = 1'b0;
    case (phase)
      0: if (start_now) begin
        phase = 1; m_div = d; m_burst = int'(burst_len); m_taken = 0; m_ovr = 0;
        next_push = edge_cnt + d; e0 = edge_cnt;
      end
      1: begin
        if (push_now) begin
          if (q.size() < DEPTH) q.push_back(edge_cnt & 'hfff);
          else if (m_ovr < 255) m_ovr++;
          m_taken++;
          next_push += m_div;
        end
        if (stop_now || (push_now && m_burst != 0 && m_taken == m_burst)) phase = 2;
      end
      default: if (pre_empty) begin
        phase = 0; exp_done = 1'b1; done_edge = edge_cnt;
      end
    endcase
    #1;
    adc_data = SW'(edge_cnt + 1);
    chk("tick", int'(sample_tick), int'(push_now));
    chk("done", int'(done), int'(exp_done));
    chk("busy", int'(busy), int'(phase != 0));
    chk("out_valid", int'(out_valid), int'(q.size() != 0));
    chk("overrun", int'(overrun), int'(m_ovr > 0));
    chk("overrun_cnt", int'(overrun_cnt), m_ovr);
    if (sample_tick) begin
      tick_count++;
      if (last_tick_edge >= 0) tick_gap = edge_cnt - last_tick_edge;
      last_tick_edge = edge_cnt;
    end
  endtask

  task automatic run_until_done(input int max);
    bit got = 1'b0;
    for (int i = 0; i < max && !got; i++) begin
      step();
      if (done) got = 1'b1;
    end
    if (!got) chk("done_timeout", 0, 1);
  endtask

  task automatic begin_run(input int dv, input int bl, input logic rdy);
    divisor = 16'(dv); burst_len = 16'(bl); out_ready = rdy;
    last_tick_edge = -1; tick_gap = 0; pops = 0; tick_count = 0;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic step_to_tick(input int max);
    int i = 0;
    while (edge_cnt + 1 != next_push && i < max) begin
      step();
      i++;
    end
    if (edge_cnt + 1 != next_push) chk("tick_wait_timeout", 0, 1);
  endtask

  initial begin
    int cnt_before;
    int i;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; out_ready = 1'b0;
    divisor = 16'd4; burst_len = 16'd0; adc_data = SW'(1);
    #12;
    chk("rst_tick", int'(sample_tick), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ovr_cnt", int'(overrun_cnt), 0);
    rst_n = 1'b1;
    stop = 1'b1;
    step();
    stop = 1'b0;

    // Basic burst of three, divisor 4
    begin_run(4, 3, 1'b1);
    run_until_done(40);
    chk("burst_done_latency", done_edge - e0, 14);
    chk("burst_period", tick_gap, 4);
    chk("burst_words", pops, 3);

    // Divisor 0 clamps to a period of 2
    begin_run(0, 4, 1'b1);
    run_until_done(40);
    chk("clamp_period", tick_gap, 2);
    chk("clamp_ticks", tick_count, 4);

    // Overrun with a stalled consumer
    begin_run(2, 12, 1'b0);
    i = 0;
    while (phase != 2 && i < 60) begin step(); i++; end
    chk("ovr_cnt_value", int'(overrun_cnt), 4);
    chk("ovr_flag_set", int'(overrun), 1);
    pops = 0;
    out_ready = 1'b1;
    run_until_done(40);
    chk("ovr_drained_words", pops, 8);

    // Full FIFO with a pop on the tick edge
    begin_run(2, 0, 1'b0);
    i = 0;
    while (q.size() < DEPTH && i < 60) begin step(); i++; end
    step_to_tick(10);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("full_pop_no_ovr", int'(overrun_cnt), 0);
    step_to_tick(10);
    step();
    chk("full_stays_full", int'(overrun_cnt), 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    out_ready = 1'b1;
    run_until_done(40);

    // Continuous with stop on a tick edge
    begin_run(5, 0, 1'b1);
    for (int k = 0; k < 12; k++) step();
    step_to_tick(10);
    cnt_before = tick_count;
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_tick_captured", int'(sample_tick), 1);
    run_until_done(40);
    chk("no_tick_after_stop", tick_count, cnt_before + 1);

    // Start while busy is ignored, then reset mid-run at occupancy 3
    begin_run(3, 0, 1'b0);
    divisor = 16'd7;
    start = 1'b1;
    step(); step();
    start = 1'b0;
    i = 0;
    while (q.size() < 3 && i < 40) begin step(); i++; end
    chk("start_ignored_period", tick_gap, 3);
    chk("occupancy_before_rst", q.size(), 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", int'(out_valid), 0);
    chk("arst_data", int'(out_data), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_tick", int'(sample_tick), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_overrun", int'(overrun), 0);
    q.delete();
    phase = 0;
    m_ovr = 0;
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
